rom_fetch: RTL and testbench
============================

# rom_fetch

Bus-side fetch sequencer between the W65C832 core's memory access logic and the SD-card-backed paged ROM (the 512-byte page buffer, one byte per access). Accepts one 8/16/32-bit little-endian read request from the core, issues the required byte reads to the pager, waits out page loads via the pager's `busy`, and returns an assembled, zero-extended word with a one-cycle `ready` pulse. A timeout flags a card that never finishes a page load.

## Interface
- `TIMEOUT`, default 24'd12000000 — max consecutive busy cycles per byte before error (≈1 s @ 12 MHz).
- `clk`  in  1  system clock (12 MHz on iceFUN).
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_address`  in  24  byte address of the first (least significant) byte.
- `cpu_size`  in  2  width: 0 = 8-bit, 1 = 16-bit, 2 or 3 = 32-bit.
- `cpu_start`  in  1  request strobe; sampled only in IDLE.
- `cpu_data`  out  32  assembled result, zero-extended.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_error`  out  1  valid with `cpu_ready`; 1 = timeout.
- `cpu_busy`  out  1  high while a request is in progress.
- `rom_address`  out  24  byte address to pager (registered).
- `rom_enable`  out  1  pager enable (registered).
- `rom_data`  in  8  pager byte output (registered in pager).
- `rom_busy`  in  1  pager busy (registered in pager; stale for one cycle after an address change).

## Operation
- Reset values: `cpu_data`=0, `cpu_ready`=0, `cpu_error`=0, `cpu_busy`=0, `rom_address`=0, `rom_enable`=0, state=IDLE, byte index=0, timeout counter=0.
- Reset mid-request abandons it. No `cpu_ready` is produced. All outputs return to reset values.
- `rom_enable` is high only in SETTLE and SAMPLE. The pager's SD init sequence therefore runs during the first request, whose latency includes it.
- Byte count N = 1, 2, 4 from `cpu_size`. Byte i lands in `cpu_data[8i+7:8i]`.
- IDLE:
  - `cpu_ready`<=0.
  - On `cpu_start`: latch N; `rom_address`<=`cpu_address`; `rom_enable`<=1; `cpu_busy`<=1; `cpu_data`<=0; `cpu_error`<=0; index<=0; timer<=0; go SETTLE.
- SETTLE: one dead cycle so the pager registers the new address before `rom_busy` is trusted. Go SAMPLE.
- SAMPLE:
  - If `rom_busy`=1: timer<=timer+1.
    - If timer reaches `TIMEOUT`: `cpu_error`<=1, `cpu_ready`<=1, `cpu_busy`<=0, `rom_enable`<=0; go IDLE.
    - Bytes already captured are kept; remaining lanes stay 0.
  - If `rom_busy`=0: store `rom_data` into lane index; timer<=0.
    - If index=N-1: `cpu_ready`<=1, `cpu_busy`<=0, `rom_enable`<=0; go IDLE.
    - Else: index<=index+1; `rom_address`<=`rom_address`+1; go SETTLE.
- Address increment is modulo 2^24: 0xFFFFFF wraps to 0x000000.
- A multi-byte read crossing a 512-byte page boundary triggers a pager load mid-request. This is handled by the busy wait.
- `cpu_start` while not IDLE is ignored; there is no queueing. `cpu_start` in the cycle `cpu_ready` is high is accepted, because the state is already IDLE.
- `cpu_size`/`cpu_address` changes after acceptance have no effect.

## Timing
- `cpu_start` sampled at edge 0. If every byte hits the resident page, byte i is captured at edge 2(i+1).
- `cpu_ready` is high in the cycle after edge 2N: 8-bit → after edge 2, 16-bit → after edge 4, 32-bit → after edge 8.
- Each page miss adds the pager's load time. Per-byte busy time is bounded by `TIMEOUT` cycles.
- `cpu_busy` is high from the cycle after acceptance through the last SAMPLE cycle. It falls in the same cycle `cpu_ready` rises.
- `cpu_data` is stable from `cpu_ready` until the next accepted start.

## Test plan
- Reset asserted mid-SAMPLE with pager model held busy → all outputs 0 within the same cycle; no `cpu_ready`; next request proceeds normally.
- Page resident, memory[0x000100..103]=11,22,33,44; 32-bit read at 0x000100 → `cpu_data`=0x44332211, `cpu_ready` 1 cycle after edge 8, `cpu_error`=0; 8-bit read → 0x00000011 after edge 2.
- 16-bit read at 0x0001FF with page 0 resident → pager model asserts busy 1000 cycles for page 1; `cpu_data`=0x0000{mem[0x200]}{mem[0x1FF]}; latency 4+1000 cycles ±1.
- 32-bit read at 0xFFFFFE → `rom_address` sequence FFFFFE, FFFFFF, 000000, 000001; bytes assembled in that order.
- `TIMEOUT`=16, pager stuck busy on byte 1 of a 32-bit read → `cpu_ready`=1 and `cpu_error`=1 after 16 busy cycles; `cpu_data`=0x000000{byte0}; `rom_enable`=0.
- `cpu_start` pulsed during an active request → ignored. `cpu_start` held in the `cpu_ready` cycle → back-to-back request accepted, `cpu_busy` high the next cycle.

Source files
------------

// File: rtl/rom_fetch.sv
// rom_fetch: assembles 8/16/32-bit little-endian reads from a byte-wide paged ROM.
// Waits out pager loads via rom_busy and flags a per-byte busy timeout. Rev 1.0
`default_nettype none

module rom_fetch #(
  parameter logic [23:0] TIMEOUT = 24'd12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] cpu_address,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_start,
  output logic [31:0] cpu_data,
  output logic        cpu_ready,
  output logic        cpu_error,
  output logic        cpu_busy,
  output logic [23:0] rom_address,
  output logic        rom_enable,
  input  logic [7:0]  rom_data,
  input  logic        rom_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  index;
  logic [1:0]  last_index;
  logic [23:0] timer;
  logic [23:0] timer_next;

  assign timer_next = timer + 24'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      index       <= 2'd0;
      last_index  <= 2'd0;
      timer       <= 24'd0;
      cpu_data    <= 32'd0;
      cpu_ready   <= 1'b0;
      cpu_error   <= 1'b0;
      cpu_busy    <= 1'b0;
      rom_address <= 24'd0;
      rom_enable  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_start) begin
            last_index  <= (cpu_size == 2'd0) ? 2'd0 :
                           (cpu_size == 2'd1) ? 2'd1 : 2'd3;
            rom_address <= cpu_address;
            rom_enable  <= 1'b1;
            cpu_busy    <= 1'b1;
            cpu_data    <= 32'd0;
            cpu_error   <= 1'b0;
            index       <= 2'd0;
            timer       <= 24'd0;
            state       <= SETTLE;
          end
        end

        // The pager's busy flag lags an address change by one cycle.
        SETTLE: state <= SAMPLE;

        SAMPLE: begin
          if (rom_busy) begin
            timer <= timer_next;
            if (timer_next >= TIMEOUT) begin
              cpu_error  <= 1'b1;
              cpu_ready  <= 1'b1;
              cpu_busy   <= 1'b0;
              rom_enable <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            cpu_data[{index, 3'b000} +: 8] <= rom_data;
            timer <= 24'd0;
            if (index == last_index) begin
              cpu_ready  <= 1'b1;
              cpu_busy   <= 1'b0;
              rom_enable <= 1'b0;
              state      <= IDLE;
            end else begin
              index       <= index + 2'd1;
              rom_address <= rom_address + 24'd1;
              state       <= SETTLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: scoreboard bench for rom_fetch with a registered paged-ROM model.
`default_nettype none

module tb_rom_fetch;

  localparam logic [23:0] TMO = 24'd1200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] cpu_address = 24'd0;
  logic [1:0]  cpu_size = 2'd0;
  logic        cpu_start = 1'b0;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic        cpu_error;
  logic        cpu_busy;
  logic [23:0] rom_address;
  logic        rom_enable;
  logic [7:0]  rom_data = 8'd0;
  logic        rom_busy = 1'b0;

  rom_fetch #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_size(cpu_size), .cpu_start(cpu_start),
    .cpu_data(cpu_data), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
    .cpu_busy(cpu_busy), .rom_address(rom_address), .rom_enable(rom_enable),
    .rom_data(rom_data), .rom_busy(rom_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Pager model: 512-byte pages, registered data and busy, configurable load time.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  logic [14:0] resident = 15'd0;
  int          load_len = 5;
  int          load_cnt = 0;
  logic        stuck_en = 1'b0;
  logic [23:0] stuck_addr = 24'd0;

  always @(posedge clk) begin
    if (stuck_en && rom_enable && rom_address == stuck_addr) begin
      rom_busy <= 1'b1;
    end else if (load_cnt != 0) begin
      load_cnt <= load_cnt - 1;
      rom_busy <= (load_cnt != 1);
      if (load_cnt == 1) resident <= rom_address[23:9];
    end else if (rom_enable && rom_address[23:9] != resident) begin
      load_cnt <= load_len;
      rom_busy <= 1'b1;
    end else begin
      rom_busy <= 1'b0;
    end
    rom_data <= mem_byte(rom_address);
  end

  logic [23:0] addr_log[$];
  always @(negedge clk) begin
    if (rom_enable && (addr_log.size() == 0 || addr_log[$] != rom_address))
      addr_log.push_back(rom_address);
  end

  // Scoreboard
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (!reset && cpu_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {31'd0, cpu_ready}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", cpu_data, e.data);
        check("error", {31'd0, cpu_error}, {31'd0, e.err});
        check("ready_cycle", cyc, e.cyc);
        check("busy_at_ready", {31'd0, cpu_busy}, 32'd0);
        check("enable_at_ready", {31'd0, rom_enable}, 32'd0);
      end
    end
  end

  task automatic expect_resp(input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.data = d; x.err = e; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic request(input logic [23:0] a, input logic [1:0] s,
                         input logic [31:0] d, input logic e, input int lat);
    @(negedge clk);
    cpu_address = a; cpu_size = s; cpu_start = 1'b1;
    expect_resp(d, e, cyc + 1 + lat);
    @(negedge clk);
    cpu_start = 1'b0;
    check("busy_after_start", {31'd0, cpu_busy}, 32'd1);
    drain(lat + 40);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, cpu_data, 32'd0);
    check({tag, "_ready"}, {31'd0, cpu_ready}, 32'd0);
    check({tag, "_error"}, {31'd0, cpu_error}, 32'd0);
    check({tag, "_busy"}, {31'd0, cpu_busy}, 32'd0);
    check({tag, "_rom_addr"}, {8'd0, rom_address}, 32'd0);
    check({tag, "_rom_en"}, {31'd0, rom_enable}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    request(24'h000100, 2'd2, 32'h44332211, 1'b0, 8);
    request(24'h000100, 2'd0, 32'h00000011, 1'b0, 2);

    // Start held high: ignored mid-request, accepted in the ready cycle.
    @(negedge clk);
    cpu_address = 24'h000101; cpu_size = 2'd0; cpu_start = 1'b1;
    expect_resp(32'h00000022, 1'b0, cyc + 1 + 2);
    expect_resp(32'h00004433, 1'b0, cyc + 1 + 7);
    @(negedge clk);
    cpu_address = 24'h000102; cpu_size = 2'd1;
    repeat (3) @(negedge clk);
    check("b2b_busy", {31'd0, cpu_busy}, 32'd1);
    cpu_start = 1'b0;
    drain(40);

    // Page crossing into page 1: 1000-cycle load.
    load_len = 1000;
    request(24'h0001FF, 2'd1, 32'h0000A75B, 1'b0, 4 + 1000);

    // One cycle under the timeout still succeeds.
    load_len = int'(TMO) - 1;
    request(24'h000400, 2'd0, 32'h000000A1, 1'b0, 2 + int'(TMO) - 1);

    // Stuck on byte 1: timeout after TMO busy samples, byte 0 kept.
    stuck_en = 1'b1; stuck_addr = 24'h000405;
    request(24'h000404, 2'd2, 32'h000000A5, 1'b1, 3 + int'(TMO));
    stuck_en = 1'b0;

    // Address wrap with two page loads.
    load_len = 5;
    addr_log.delete();
    request(24'hFFFFFE, 2'd3, 32'hA4A55A5B, 1'b0, 8 + 5 + 5);
    check("wrap_log_size", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      check("wrap_addr0", {8'd0, addr_log[0]}, 32'h00FFFFFE);
      check("wrap_addr1", {8'd0, addr_log[1]}, 32'h00FFFFFF);
      check("wrap_addr2", {8'd0, addr_log[2]}, 32'h00000000);
      check("wrap_addr3", {8'd0, addr_log[3]}, 32'h00000001);
    end

    // Start pulsed mid-request is ignored.
    @(negedge clk);
    cpu_address = 24'h000100; cpu_size = 2'd2; cpu_start = 1'b1;
    expect_resp(32'h44332211, 1'b0, cyc + 1 + 8);
    @(negedge clk);
    cpu_start = 1'b0;
    repeat (2) @(negedge clk);
    cpu_address = 24'h000000; cpu_size = 2'd0; cpu_start = 1'b1;
    @(negedge clk);
    cpu_start = 1'b0;
    drain(40);
    repeat (10) @(negedge clk);

    // Reset while waiting on a busy pager abandons the request.
    stuck_en = 1'b1; stuck_addr = 24'h000010;
    @(negedge clk);
    cpu_address = 24'h000010; cpu_size = 2'd0; cpu_start = 1'b1;
    @(negedge clk);
    cpu_start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'd0, cpu_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0; stuck_en = 1'b0;
    repeat (5) @(negedge clk);
    request(24'h000100, 2'd0, 32'h00000011, 1'b0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
